// File: rtl/regfile_scoreboard.sv
// +----------------------------------------------------------------------------+
// | regfile_scoreboard: 2R/1W register file with write-to-read bypass, r0 = 0, |
// | and per-register busy scoreboard raising stall on RAW/WAW hazards.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      ra_addr_i,
  input  logic [ADDR_W-1:0]      rb_addr_i,
  output logic [DATA_W-1:0]      ra_data_o,
  output logic [DATA_W-1:0]      rb_data_o,
  input  logic                   wb_en_i,
  input  logic [ADDR_W-1:0]      wb_addr_i,
  input  logic [DATA_W-1:0]      wb_data_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_ra_used_i,
  input  logic                   issue_rb_used_i,
  input  logic                   issue_wr_i,
  input  logic [ADDR_W-1:0]      issue_rd_i,
  output logic                   stall_o,
  output logic [(2**ADDR_W)-1:0] busy_vec_o,
  output logic [CNT_W-1:0]       pending_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DEPTH-1:0]  clr_vec;
  logic              wb_real;
  logic              raw_a, raw_b, waw;
  logic              accept;
  logic              retire_busy;

  assign wb_real = wb_en_i && (wb_addr_i != '0);

  always_comb begin
    clr_vec = '0;
    if (wb_real) clr_vec[wb_addr_i] = 1'b1;
  end

  // busy_q[0] is never set, so r0 sources/destinations can never hazard
  assign raw_a   = issue_ra_used_i && busy_q[ra_addr_i]  && !clr_vec[ra_addr_i];
  assign raw_b   = issue_rb_used_i && busy_q[rb_addr_i]  && !clr_vec[rb_addr_i];
  assign waw     = issue_wr_i      && busy_q[issue_rd_i] && !clr_vec[issue_rd_i];
  assign stall_o = issue_valid_i && (raw_a || raw_b || waw);
  assign accept  = issue_valid_i && !stall_o && issue_wr_i && (issue_rd_i != '0);

  assign retire_busy = |(clr_vec & busy_q);

  always_comb begin
    ra_data_o = mem_q[ra_addr_i];
    if (ra_addr_i == '0)
      ra_data_o = '0;
    else if (wb_en_i && (wb_addr_i == ra_addr_i))
      ra_data_o = wb_data_i;
  end

  always_comb begin
    rb_data_o = mem_q[rb_addr_i];
    if (rb_addr_i == '0)
      rb_data_o = '0;
    else if (wb_en_i && (wb_addr_i == rb_addr_i))
      rb_data_o = wb_data_i;
  end

  // Set after clear: a new producer replaces a retiring one on the same register
  always_comb begin
    busy_d = busy_q & ~clr_vec;
    if (accept) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !retire_busy)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && retire_busy)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wb_real) begin
      mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec_o    = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_scoreboard: directed and random stimulus with a queued          |
// | scoreboard checked by an independent negedge monitor.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;
  localparam int DEPTH  = 32;

  // mask bits: 0 ra_data, 1 rb_data, 2 stall, 3 busy_vec, 4 pending_cnt
  localparam logic [4:0] M_ALL = 5'b11111;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] ra_addr, rb_addr, wb_addr, issue_rd;
  logic [DATA_W-1:0] ra_data, rb_data, wb_data;
  logic              wb_en, issue_valid, issue_ra_used, issue_rb_used, issue_wr;
  logic              stall;
  logic [DEPTH-1:0]  busy_vec;
  logic [CNT_W-1:0]  pending_cnt;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ra_addr_i      (ra_addr),
    .rb_addr_i      (rb_addr),
    .ra_data_o      (ra_data),
    .rb_data_o      (rb_data),
    .wb_en_i        (wb_en),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .issue_valid_i  (issue_valid),
    .issue_ra_used_i(issue_ra_used),
    .issue_rb_used_i(issue_rb_used),
    .issue_wr_i     (issue_wr),
    .issue_rd_i     (issue_rd),
    .stall_o        (stall),
    .busy_vec_o     (busy_vec),
    .pending_cnt_o  (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [4:0]  mask;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        st;
    logic [31:0] bv;
    logic [5:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
  endtask

  // Monitor: outputs are stable at negedge for the inputs driven after the last posedge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.mask[0]) cmp(e.nm, "ra_data", ra_data, e.ra);
      if (e.mask[1]) cmp(e.nm, "rb_data", rb_data, e.rb);
      if (e.mask[2]) cmp(e.nm, "stall", {31'd0, stall}, {31'd0, e.st});
      if (e.mask[3]) cmp(e.nm, "busy_vec", busy_vec, e.bv);
      if (e.mask[4]) cmp(e.nm, "pending_cnt", {26'd0, pending_cnt}, {26'd0, e.cnt});
      cmp(e.nm, "cnt_vs_popcount", {26'd0, pending_cnt}, 32'($countones(busy_vec)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] mask, input logic [31:0] ra,
                     input logic [31:0] rb, input logic st, input logic [31:0] bv,
                     input logic [5:0] cnt);
    exp_t e;
    e.nm = nm; e.mask = mask; e.ra = ra; e.rb = rb; e.st = st; e.bv = bv; e.cnt = cnt;
    q.push_back(e);
    tick();
  endtask

  task automatic idle();
    wb_en = 0; wb_addr = 0; wb_data = 0;
    issue_valid = 0; issue_ra_used = 0; issue_rb_used = 0; issue_wr = 0; issue_rd = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic issue(input logic ru, input logic rbu, input logic w, input logic [4:0] rd);
    issue_valid = 1; issue_ra_used = ru; issue_rb_used = rbu; issue_wr = w; issue_rd = rd;
  endtask

  // Reference model for the random phase
  logic [31:0] mem_m [DEPTH];
  logic [31:0] busy_m;
  int          cnt_m;

  task automatic rand_cycle();
    exp_t  e;
    logic  clr_a, clr_b, clr_d, rawa, rawb, waw_h, st, acc, dec;
    clr_a = wb_en && wb_addr == ra_addr  && ra_addr  != 0;
    clr_b = wb_en && wb_addr == rb_addr  && rb_addr  != 0;
    clr_d = wb_en && wb_addr == issue_rd && issue_rd != 0;
    rawa  = issue_ra_used && busy_m[ra_addr]  && !clr_a;
    rawb  = issue_rb_used && busy_m[rb_addr]  && !clr_b;
    waw_h = issue_wr      && busy_m[issue_rd] && !clr_d;
    st    = issue_valid && (rawa || rawb || waw_h);
    e.nm   = "random";
    e.mask = M_ALL;
    e.ra   = (ra_addr == 0) ? 32'd0 : (wb_en && wb_addr == ra_addr) ? wb_data : mem_m[ra_addr];
    e.rb   = (rb_addr == 0) ? 32'd0 : (wb_en && wb_addr == rb_addr) ? wb_data : mem_m[rb_addr];
    e.st   = st;
    e.bv   = busy_m;
    e.cnt  = 6'(cnt_m);
    q.push_back(e);
    @(posedge clk);
    acc = issue_valid && !st && issue_wr && issue_rd != 0;
    dec = wb_en && wb_addr != 0 && busy_m[wb_addr];
    if (wb_en && wb_addr != 0) begin
      mem_m[wb_addr] = wb_data;
      busy_m[wb_addr] = 1'b0;
    end
    if (acc) busy_m[issue_rd] = 1'b1;
    cnt_m = cnt_m + (acc ? 1 : 0) - (dec ? 1 : 0);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle(); ra_addr = 1; rb_addr = 2;
    tick();
    chk("reset", M_ALL, 0, 0, 0, 0, 0);
    rst_n = 1;
    tick();

    // Basic write then read
    wb(1, 32'h0000_1234); tick();
    wb(2, 32'h0000_2345); tick();
    idle(); ra_addr = 1; rb_addr = 2;
    chk("t1_read", M_ALL, 32'h1234, 32'h2345, 0, 0, 0);

    // r0 write ignored; same-cycle bypass
    wb(0, 32'hDEAD_BEEF); ra_addr = 0;
    chk("t2_r0_wb", 5'b00001, 0, 0, 0, 0, 0);
    idle(); ra_addr = 0;
    chk("t2_r0_after", 5'b00001, 0, 0, 0, 0, 0);
    wb(3, 32'h0000_4567); ra_addr = 3;
    chk("t2_bypass", 5'b00011, 32'h4567, 32'h2345, 0, 0, 0);
    idle(); ra_addr = 3;
    chk("t2_stored", 5'b00001, 32'h4567, 0, 0, 0, 0);

    // RAW on r4 resolved by same-cycle write-back
    issue(0, 0, 1, 4);
    chk("t3_issue4", 5'b11100, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0); ra_addr = 4;
    chk("t3_raw_stall", M_ALL, 0, 32'h2345, 1, 32'h10, 1);
    wb(4, 32'h0000_5678);
    chk("t3_raw_bypass", M_ALL, 32'h5678, 32'h2345, 0, 32'h10, 1);
    idle(); ra_addr = 4;
    chk("t3_retired", M_ALL, 32'h5678, 32'h2345, 0, 0, 0);

    // RAW on port B
    issue(0, 0, 1, 9); tick();
    idle(); issue(0, 1, 0, 0); rb_addr = 9;
    chk("rawB_stall", 5'b11100, 0, 0, 1, 32'h200, 1);
    idle(); wb(9, 32'h99); tick();

    // WAW on r5, then replace producer in retirement cycle
    idle(); issue(0, 0, 1, 5); tick();
    issue(0, 0, 1, 5);
    chk("t4_waw", 5'b11100, 0, 0, 1, 32'h20, 1);
    wb(5, 32'h0000_9ABC);
    chk("t4_replace", 5'b11100, 0, 0, 0, 32'h20, 1);
    idle();
    chk("t4_set_wins", 5'b11000, 0, 0, 0, 32'h20, 1);
    wb(5, 32'h1); tick();
    idle(); wb(10, 32'hAAAA);
    chk("no_underflow_pre", 5'b11000, 0, 0, 0, 0, 0);
    idle(); ra_addr = 10;
    chk("no_underflow", 5'b11001, 32'hAAAA, 0, 0, 0, 0);

    // Accept and retire of different registers in one cycle
    issue(0, 0, 1, 5); tick();
    idle(); issue(0, 0, 1, 6); wb(5, 32'h55); tick();
    idle();
    chk("diff_acc_clr", 5'b11000, 0, 0, 0, 32'h40, 1);
    issue(0, 0, 1, 7); tick();
    issue(0, 0, 1, 8); tick();
    idle(); ra_addr = 1; rb_addr = 2;
    chk("t5_three", M_ALL, 32'h1234, 32'h2345, 0, 32'h1C0, 3);

    // Async reset mid-cycle, checked before the next clock edge
    rst_n = 0;
    chk("t5_async_reset", M_ALL, 0, 0, 0, 0, 0);
    rst_n = 1;

    // Random stream against the reference model
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    busy_m = 0;
    cnt_m  = 0;
    for (int c = 0; c < 10000; c++) begin
      wb_en         = 1'($urandom_range(0, 1));
      wb_addr       = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      ra_addr       = 5'($urandom_range(0, 7));
      rb_addr       = 5'($urandom_range(0, 7));
      issue_valid   = 1'($urandom_range(0, 1));
      issue_ra_used = 1'($urandom_range(0, 1));
      issue_rb_used = 1'($urandom_range(0, 1));
      issue_wr      = 1'($urandom_range(0, 1));
      issue_rd      = 5'($urandom_range(0, 7));
      rand_cycle();
    end

    idle();
    repeat (3) tick();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
